serial_byte_rx: RTL and testbench

- Receiving end of the single-bit line `d` that the buffer example drives.
- Recovers UART-style frames from `d`: start bit low, 8 data bits LSB-first, stop bit high, idle high.
- Presents each received byte on a valid/ready output register.
- Sits between an external 1-bit line and any byte-wide consumer in the same clock domain.

---
 rtl/serial_byte_rx.sv | 102 ++++++++++
 tb/tb_serial_byte_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_rx.sv
// UART-style byte receiver: synchronizes the serial line, recovers start/8 data/stop
// frames, and presents each byte on a valid/ready register with error pulses.
module serial_byte_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       d,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_next;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                 ds;
  logic [TW-1:0]        tick;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic                 tick_done, tick_mid, sample, stop_sample, load, ferr;

  // Input synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!reset_n) sync_p0 <= '1;
    else          sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
  end

  assign ds = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    tick_done   = (tick == TICK_LAST);
    tick_mid    = (tick == TICK_MID);
    sample      = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE:  if (!ds) state_next = START;
      START: if (tick_mid) state_next = ds ? IDLE : DATA;
      DATA: begin
        sample = tick_done;
        if (tick_done && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        stop_sample = tick_done;
        if (tick_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    load = stop_sample & ds;
    ferr = stop_sample & ~ds;
  end

  // Bit timing, shift register and output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE:    tick <= '0;
        START:   tick <= tick_mid ? '0 : tick + 1'b1;
        default: tick <= tick_done ? '0 : tick + 1'b1;
      endcase

      if (state == START && tick_mid) bit_idx <= '0;
      else if (sample)                bit_idx <= bit_idx + 1'b1;

      if (sample) shreg <= {ds, shreg[7:1]};

      frame_err <= ferr;
      overrun   <= load & valid & ~ready;

      // A load wins over a concurrent handshake: the fresh byte stays valid
      if (load) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx: stimulus pushes expected output events into a
// queue, and an independent monitor pops and compares whenever the DUT reports one.
module tb_serial_byte_rx;

  localparam int CPB = 4;
  localparam int SYNC = 2;

  localparam logic [1:0] K_VLD = 2'd0;
  localparam logic [1:0] K_OVR = 2'd1;
  localparam logic [1:0] K_FER = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       d = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int   vectors = 0;
  int   errors = 0;
  exp_t q[$];

  serial_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .d(d), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    d = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    d = 1'b1;
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.data = val;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    d = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: an event is a frame_err pulse, an overrun pulse, or a rising valid
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic       ev;
    logic [1:0] kind;
    exp_t       e;
    ev   = 1'b0;
    kind = K_VLD;
    if (frame_err === 1'b1)                    begin ev = 1'b1; kind = K_FER; end
    else if (overrun === 1'b1)                 begin ev = 1'b1; kind = K_OVR; end
    else if (valid === 1'b1 && !prev_valid)    begin ev = 1'b1; kind = K_VLD; end
    if (ev) begin
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kind %0d data %02h, expected no event", kind, data);
      end else begin
        e = q.pop_front();
        if (kind !== e.kind || data !== e.data || valid !== (e.kind != K_FER)) begin
          errors++;
          $display("FAIL event: got kind %0d data %02h valid %0b, expected kind %0d data %02h valid %0b",
                   kind, data, valid, e.kind, e.data, (e.kind != K_FER));
        end
      end
    end
    prev_valid = (valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    reset_n = 1'b1;
    idle(4);

    // Basic byte, valid must last exactly one cycle with ready held high
    expect_ev(K_VLD, 8'hA5);
    send_frame(8'hA5, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("basic_one_cycle", valid, 0);
    idle(6);

    // Back-to-back frames with no idle gap
    expect_ev(K_VLD, 8'h00);
    expect_ev(K_VLD, 8'hFF);
    expect_ev(K_VLD, 8'h3C);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(8);

    // Backpressure then overrun
    ready = 1'b0;
    expect_ev(K_VLD, 8'h12);
    send_frame(8'h12, 1'b1);
    idle(6);
    check("hold_valid", valid, 1);
    check("hold_data", data, 8'h12);
    idle(6);
    check("hold_data_later", data, 8'h12);
    expect_ev(K_OVR, 8'h34);
    send_frame(8'h34, 1'b1);
    idle(6);
    check("ovr_valid", valid, 1);
    check("ovr_data", data, 8'h34);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("handshake_clear", valid, 0);
    idle(4);
    ready = 1'b1;

    // Framing error leaves data and valid alone, then a good frame follows
    expect_ev(K_FER, 8'h34);
    send_frame(8'h55, 1'b0);
    idle(12);
    check("ferr_valid", valid, 0);
    check("ferr_data", data, 8'h34);
    expect_ev(K_VLD, 8'h81);
    send_frame(8'h81, 1'b1);
    idle(8);

    // Glitch shorter than half a bit after synchronization
    d = 1'b0;
    @(posedge clk);
    #1;
    idle(20);
    check("glitch_valid", valid, 0);
    check("glitch_ferr", frame_err, 0);

    // Reset during data bit 4 of 0xC3
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_valid", valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovr", overrun, 0);
    reset_n = 1'b1;
    idle(12);
    expect_ev(K_VLD, 8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(10);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
